// File: rtl/ddr_cmd_arbiter.sv
// Inter-bank command arbiter: REF > RD/WR > ACT > PRE, round-robin inside a class, tRRD/tCCD/tWTR/tRTW
// spacing, one registered DRAM command per cycle. Optional four-activate window under DDR_ARB_TFAW_EN.
`ifndef DRAM_BA_WIDTH
`define DRAM_BA_WIDTH 2
`endif
`ifndef DRAM_RA_WIDTH
`define DRAM_RA_WIDTH 14
`endif
`ifndef DRAM_CA_WIDTH
`define DRAM_CA_WIDTH 10
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef T_RRD_WIDTH
`define T_RRD_WIDTH 4
`endif
`ifndef T_CCD_WIDTH
`define T_CCD_WIDTH 4
`endif
`ifndef T_WTR_WIDTH
`define T_WTR_WIDTH 4
`endif
`ifndef T_RTW_WIDTH
`define T_RTW_WIDTH 4
`endif

module ddr_cmd_arbiter #(
    parameter int NUM_BANKS = 4,
    parameter int T_FAW     = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_BANKS-1:0]                   act_req,
    input  logic [NUM_BANKS-1:0]                   rd_req,
    input  logic [NUM_BANKS-1:0]                   wr_req,
    input  logic [NUM_BANKS-1:0]                   pre_req,
    input  logic [NUM_BANKS-1:0]                   ref_req,
    input  logic [NUM_BANKS*`DRAM_RA_WIDTH-1:0]    ra,
    input  logic [NUM_BANKS*`DRAM_CA_WIDTH-1:0]    ca,
    input  logic [NUM_BANKS*`AXI_ID_WIDTH-1:0]     id,
    input  logic [NUM_BANKS*`AXI_LEN_WIDTH-1:0]    len,
    output logic [NUM_BANKS-1:0]                   act_gnt,
    output logic [NUM_BANKS-1:0]                   rd_gnt,
    output logic [NUM_BANKS-1:0]                   wr_gnt,
    output logic [NUM_BANKS-1:0]                   pre_gnt,
    output logic [NUM_BANKS-1:0]                   ref_gnt,
    input  logic [`T_RRD_WIDTH-1:0]                t_rrd_m1,
    input  logic [`T_CCD_WIDTH-1:0]                t_ccd_m1,
    input  logic [`T_WTR_WIDTH-1:0]                t_wtr_m1,
    input  logic [`T_RTW_WIDTH-1:0]                t_rtw_m1,
    output logic                                   cmd_valid,
    output logic [2:0]                             cmd_type,
    output logic [`DRAM_BA_WIDTH-1:0]              cmd_ba,
    output logic [`DRAM_RA_WIDTH-1:0]              cmd_ra,
    output logic [`DRAM_CA_WIDTH-1:0]              cmd_ca,
    output logic [`AXI_ID_WIDTH-1:0]               cmd_id,
    output logic [`AXI_LEN_WIDTH-1:0]              cmd_len
);
    localparam int BA_W = `DRAM_BA_WIDTH;
    localparam logic [2:0] CMD_NOP = 3'd0, CMD_ACT = 3'd1, CMD_RD = 3'd2,
                           CMD_WR  = 3'd3, CMD_PRE = 3'd4, CMD_REF = 3'd5;

    if (NUM_BANKS != (1 << BA_W)) begin : g_bad_banks
        $error("NUM_BANKS must equal 2**DRAM_BA_WIDTH");
    end
    if (T_FAW < 1) begin : g_bad_faw
        $error("T_FAW must be at least 1");
    end

    logic [`DRAM_RA_WIDTH-1:0]  ra_arr  [NUM_BANKS];
    logic [`DRAM_CA_WIDTH-1:0]  ca_arr  [NUM_BANKS];
    logic [`AXI_ID_WIDTH-1:0]   id_arr  [NUM_BANKS];
    logic [`AXI_LEN_WIDTH-1:0]  len_arr [NUM_BANKS];

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_unpack
        assign ra_arr[gi]  = ra[gi*`DRAM_RA_WIDTH +: `DRAM_RA_WIDTH];
        assign ca_arr[gi]  = ca[gi*`DRAM_CA_WIDTH +: `DRAM_CA_WIDTH];
        assign id_arr[gi]  = id[gi*`AXI_ID_WIDTH +: `AXI_ID_WIDTH];
        assign len_arr[gi] = len[gi*`AXI_LEN_WIDTH +: `AXI_LEN_WIDTH];
    end

    logic [`T_RRD_WIDTH-1:0]   cnt_rrd_q, cnt_rrd_d;
    logic [`T_CCD_WIDTH-1:0]   cnt_ccd_q, cnt_ccd_d;
    logic [`T_WTR_WIDTH-1:0]   cnt_wtr_q, cnt_wtr_d;
    logic [`T_RTW_WIDTH-1:0]   cnt_rtw_q, cnt_rtw_d;
    logic [BA_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic                      cmd_valid_q, cmd_valid_d;
    logic [2:0]                cmd_type_q, cmd_type_d;
    logic [BA_W-1:0]           cmd_ba_q, cmd_ba_d;
    logic [`DRAM_RA_WIDTH-1:0] cmd_ra_q, cmd_ra_d;
    logic [`DRAM_CA_WIDTH-1:0] cmd_ca_q, cmd_ca_d;
    logic [`AXI_ID_WIDTH-1:0]  cmd_id_q, cmd_id_d;
    logic [`AXI_LEN_WIDTH-1:0] cmd_len_q, cmd_len_d;

    logic                 rd_ok, wr_ok, act_ok, faw_ok;
    logic [NUM_BANKS-1:0] cas_vec, act_vec, class_vec, gnt_onehot;
    logic                 gnt_valid;
    logic [BA_W-1:0]      gnt_idx;
    logic [2:0]           gnt_type;

    `ifdef DDR_ARB_TFAW_EN
    localparam int FAW_W = $clog2(T_FAW + 1);
    // Remaining-window countdown per recent ACT, newest in slot 0; the oldest is always the smallest.
    logic [FAW_W-1:0] faw_q [4];
    logic [FAW_W-1:0] faw_d [4];
    logic [FAW_W-1:0] faw_dec [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            faw_dec[i] = (faw_q[i] == '0) ? '0 : faw_q[i] - 1'b1;
            faw_d[i]   = faw_dec[i];
        end
        if (gnt_type == CMD_ACT) begin
            faw_d[0] = FAW_W'(T_FAW - 1);
            for (int i = 1; i < 4; i++) faw_d[i] = faw_dec[i-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) faw_q[i] <= rst_n ? faw_d[i] : '0;
    end

    assign faw_ok = (faw_q[3] == '0);
    `else
    assign faw_ok = 1'b1;
    `endif

    always_comb begin
        rd_ok     = (cnt_ccd_q == '0) && (cnt_wtr_q == '0);
        wr_ok     = (cnt_ccd_q == '0) && (cnt_rtw_q == '0);
        act_ok    = (cnt_rrd_q == '0) && faw_ok;
        cas_vec   = (rd_req & {NUM_BANKS{rd_ok}}) | (wr_req & {NUM_BANKS{wr_ok}});
        act_vec   = act_req & {NUM_BANKS{act_ok}};
        class_vec = '0;
        if (!rst_n)           class_vec = '0;
        else if (|ref_req)    class_vec = ref_req;
        else if (|cas_vec)    class_vec = cas_vec;
        else if (|act_vec)    class_vec = act_vec;
        else                  class_vec = pre_req;
    end

    // Rotating-priority pick starting at rr_ptr; the power-of-two bank count makes wrap a truncation.
    always_comb begin
        logic [BA_W-1:0] cand;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            cand = rr_ptr_q + k[BA_W-1:0];
            if (!gnt_valid && class_vec[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        gnt_type = CMD_NOP;
        if (gnt_valid) begin
            if (|ref_req)                        gnt_type = CMD_REF;
            else if (|cas_vec)                   gnt_type = (rd_req[gnt_idx] && rd_ok) ? CMD_RD : CMD_WR;
            else if (|act_vec)                   gnt_type = CMD_ACT;
            else                                 gnt_type = CMD_PRE;
        end
        gnt_onehot = gnt_valid ? (NUM_BANKS'(1) << gnt_idx) : '0;
        ref_gnt    = (gnt_type == CMD_REF) ? gnt_onehot : '0;
        rd_gnt     = (gnt_type == CMD_RD)  ? gnt_onehot : '0;
        wr_gnt     = (gnt_type == CMD_WR)  ? gnt_onehot : '0;
        act_gnt    = (gnt_type == CMD_ACT) ? gnt_onehot : '0;
        pre_gnt    = (gnt_type == CMD_PRE) ? gnt_onehot : '0;
    end

    // A grant reloads its counters with the current m1 value; otherwise saturating decrement.
    always_comb begin
        cnt_rrd_d = (cnt_rrd_q == '0) ? '0 : cnt_rrd_q - 1'b1;
        cnt_ccd_d = (cnt_ccd_q == '0) ? '0 : cnt_ccd_q - 1'b1;
        cnt_wtr_d = (cnt_wtr_q == '0) ? '0 : cnt_wtr_q - 1'b1;
        cnt_rtw_d = (cnt_rtw_q == '0) ? '0 : cnt_rtw_q - 1'b1;
        if (gnt_type == CMD_ACT) cnt_rrd_d = t_rrd_m1;
        if (gnt_type == CMD_RD || gnt_type == CMD_WR) cnt_ccd_d = t_ccd_m1;
        if (gnt_type == CMD_RD) cnt_rtw_d = t_rtw_m1;
        if (gnt_type == CMD_WR) cnt_wtr_d = t_wtr_m1;

        rr_ptr_d    = gnt_valid ? gnt_idx + 1'b1 : rr_ptr_q;
        cmd_valid_d = gnt_valid;
        cmd_type_d  = gnt_type;
        cmd_ba_d    = gnt_valid ? gnt_idx          : cmd_ba_q;
        cmd_ra_d    = gnt_valid ? ra_arr[gnt_idx]  : cmd_ra_q;
        cmd_ca_d    = gnt_valid ? ca_arr[gnt_idx]  : cmd_ca_q;
        cmd_id_d    = gnt_valid ? id_arr[gnt_idx]  : cmd_id_q;
        cmd_len_d   = gnt_valid ? len_arr[gnt_idx] : cmd_len_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_rrd_q   <= '0;
            cnt_ccd_q   <= '0;
            cnt_wtr_q   <= '0;
            cnt_rtw_q   <= '0;
            rr_ptr_q    <= '0;
            cmd_valid_q <= 1'b0;
            cmd_type_q  <= CMD_NOP;
            cmd_ba_q    <= '0;
            cmd_ra_q    <= '0;
            cmd_ca_q    <= '0;
            cmd_id_q    <= '0;
            cmd_len_q   <= '0;
        end else begin
            cnt_rrd_q   <= cnt_rrd_d;
            cnt_ccd_q   <= cnt_ccd_d;
            cnt_wtr_q   <= cnt_wtr_d;
            cnt_rtw_q   <= cnt_rtw_d;
            rr_ptr_q    <= rr_ptr_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_type_q  <= cmd_type_d;
            cmd_ba_q    <= cmd_ba_d;
            cmd_ra_q    <= cmd_ra_d;
            cmd_ca_q    <= cmd_ca_d;
            cmd_id_q    <= cmd_id_d;
            cmd_len_q   <= cmd_len_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_type  = cmd_type_q;
    assign cmd_ba    = cmd_ba_q;
    assign cmd_ra    = cmd_ra_q;
    assign cmd_ca    = cmd_ca_q;
    assign cmd_id    = cmd_id_q;
    assign cmd_len   = cmd_len_q;

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// Directed bench for ddr_cmd_arbiter: reset, round-robin, tRRD/tWTR/tRTW spacing, class priority,
// mid-count reset, and (with DDR_ARB_TFAW_EN) the four-activate window.
`ifndef DRAM_BA_WIDTH
`define DRAM_BA_WIDTH 2
`endif
`ifndef DRAM_RA_WIDTH
`define DRAM_RA_WIDTH 14
`endif
`ifndef DRAM_CA_WIDTH
`define DRAM_CA_WIDTH 10
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef T_RRD_WIDTH
`define T_RRD_WIDTH 4
`endif
`ifndef T_CCD_WIDTH
`define T_CCD_WIDTH 4
`endif
`ifndef T_WTR_WIDTH
`define T_WTR_WIDTH 4
`endif
`ifndef T_RTW_WIDTH
`define T_RTW_WIDTH 4
`endif

module tb_ddr_cmd_arbiter;
    localparam int NB   = 4;
    localparam int RA_W = `DRAM_RA_WIDTH;
    localparam int CA_W = `DRAM_CA_WIDTH;
    localparam int ID_W = `AXI_ID_WIDTH;
    localparam int LN_W = `AXI_LEN_WIDTH;

    logic clk = 1'b0;
    logic rst_n;
    logic [NB-1:0] act_req, rd_req, wr_req, pre_req, ref_req;
    logic [NB*RA_W-1:0] ra;
    logic [NB*CA_W-1:0] ca;
    logic [NB*ID_W-1:0] id;
    logic [NB*LN_W-1:0] len;
    logic [NB-1:0] act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
    logic [`T_RRD_WIDTH-1:0] t_rrd_m1;
    logic [`T_CCD_WIDTH-1:0] t_ccd_m1;
    logic [`T_WTR_WIDTH-1:0] t_wtr_m1;
    logic [`T_RTW_WIDTH-1:0] t_rtw_m1;
    logic cmd_valid;
    logic [2:0] cmd_type;
    logic [`DRAM_BA_WIDTH-1:0] cmd_ba;
    logic [RA_W-1:0] cmd_ra;
    logic [CA_W-1:0] cmd_ca;
    logic [ID_W-1:0] cmd_id;
    logic [LN_W-1:0] cmd_len;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ddr_cmd_arbiter #(.NUM_BANKS(NB), .T_FAW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req), .pre_req(pre_req), .ref_req(ref_req),
        .ra(ra), .ca(ca), .id(id), .len(len),
        .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .pre_gnt(pre_gnt), .ref_gnt(ref_gnt),
        .t_rrd_m1(t_rrd_m1), .t_ccd_m1(t_ccd_m1), .t_wtr_m1(t_wtr_m1), .t_rtw_m1(t_rtw_m1),
        .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_ba(cmd_ba), .cmd_ra(cmd_ra),
        .cmd_ca(cmd_ca), .cmd_id(cmd_id), .cmd_len(cmd_len)
    );

    typedef struct {
        logic [3:0] act, rd, wr, pre, rf;
        logic [3:0] rrd, ccd, wtr, rtw;
        int gt, gb, cv, ct, cb;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [RA_W-1:0] ra_of(input int b);
        return RA_W'(32'h100 + b);
    endfunction

    // Expected grant bundle laid out as {ref, rd, wr, act, pre}.
    function automatic logic [19:0] exp_bundle(input int t, input int b);
        logic [19:0] e;
        logic [3:0]  oh;
        e  = '0;
        oh = 4'b0001 << b;
        case (t)
            5: e[19:16] = oh;
            2: e[15:12] = oh;
            3: e[11:8]  = oh;
            1: e[7:4]   = oh;
            4: e[3:0]   = oh;
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] a, r, w, p, f, input logic [3:0] rrd, ccd, wtr, rtw);
        act_req = a; rd_req = r; wr_req = w; pre_req = p; ref_req = f;
        t_rrd_m1 = `T_RRD_WIDTH'(rrd);
        t_ccd_m1 = `T_CCD_WIDTH'(ccd);
        t_wtr_m1 = `T_WTR_WIDTH'(wtr);
        t_rtw_m1 = `T_RTW_WIDTH'(rtw);
    endtask

    // Inputs are already applied; compare at the falling edge, then advance past the next rising edge.
    task automatic check_cycle(input string tag, input int gt, input int gb, input int cv,
                               input int ct, input int cb, input logic [RA_W-1:0] exp_ra);
        logic [19:0] bundle;
        @(negedge clk);
        bundle = {ref_gnt, rd_gnt, wr_gnt, act_gnt, pre_gnt};
        $display("%s gnt=%05h cmd_valid=%0d cmd_type=%0d cmd_ba=%0d", tag, bundle, cmd_valid, cmd_type, cmd_ba);
        chk({tag, " gnt"}, 32'(bundle), 32'(exp_bundle(gt, gb)));
        chk({tag, " cmd_valid"}, 32'(cmd_valid), 32'(cv));
        chk({tag, " cmd_type"}, 32'(cmd_type), 32'(ct));
        chk({tag, " cmd_ba"}, 32'(cmd_ba), 32'(cb));
        chk({tag, " cmd_ra"}, 32'(cmd_ra), 32'(exp_ra));
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [3:0] a, r, w, p, f, input logic [3:0] rrd, ccd, wtr, rtw,
                       input int gt, gb, cv, ct, cb);
        vec_t v;
        v.act = a; v.rd = r; v.wr = w; v.pre = p; v.rf = f;
        v.rrd = rrd; v.ccd = ccd; v.wtr = wtr; v.rtw = rtw;
        v.gt = gt; v.gb = gb; v.cv = cv; v.ct = ct; v.cb = cb;
        tbl.push_back(v);
    endtask

    initial begin
        // act, rd, wr, pre, ref | rrd ccd wtr rtw | grant type/bank | cmd valid/type/ba (previous grant)
        add(4'h0,4'h0,4'h0,4'h0,4'h0, 0,0,0,0, 0,0, 1,5,0);
        add(4'h0,4'h0,4'h0,4'h8,4'h0, 0,0,0,0, 4,3, 0,0,0);
        add(4'hF,4'h0,4'h0,4'h0,4'h0, 0,0,0,0, 1,0, 1,4,3);   // round-robin over held ACTs
        add(4'hF,4'h0,4'h0,4'h0,4'h0, 0,0,0,0, 1,1, 1,1,0);
        add(4'hF,4'h0,4'h0,4'h0,4'h0, 0,0,0,0, 1,2, 1,1,1);
        add(4'hF,4'h0,4'h0,4'h0,4'h0, 0,0,0,0, 1,3, 1,1,2);
        add(4'h0,4'h0,4'h0,4'h0,4'h0, 0,0,0,0, 0,0, 1,1,3);
        add(4'h0,4'h0,4'h0,4'h0,4'h0, 0,0,0,0, 0,0, 0,0,3);
        add(4'h3,4'h0,4'h0,4'h0,4'h0, 3,0,0,0, 1,0, 0,0,3);   // tRRD: next ACT four cycles later
        add(4'h2,4'h0,4'h0,4'h0,4'h0, 3,0,0,0, 0,0, 1,1,0);
        add(4'h2,4'h0,4'h0,4'h0,4'h0, 3,0,0,0, 0,0, 0,0,0);
        add(4'h2,4'h0,4'h0,4'h0,4'h0, 3,0,0,0, 0,0, 0,0,0);
        add(4'h2,4'h0,4'h0,4'h0,4'h0, 3,0,0,0, 1,1, 0,0,0);
        add(4'h0,4'h0,4'h0,4'h0,4'h0, 3,0,0,0, 0,0, 1,1,1);
        add(4'h0,4'h0,4'h4,4'h0,4'h0, 0,1,5,2, 3,2, 0,0,1);   // tWTR: RD six cycles after WR
        add(4'h0,4'h8,4'h0,4'h0,4'h0, 0,1,5,2, 0,0, 1,3,2);
        add(4'h0,4'h8,4'h0,4'h0,4'h0, 0,1,5,2, 0,0, 0,0,2);
        add(4'h0,4'h8,4'h0,4'h0,4'h0, 0,1,5,2, 0,0, 0,0,2);
        add(4'h0,4'h8,4'h0,4'h0,4'h0, 0,1,5,2, 0,0, 0,0,2);
        add(4'h0,4'h8,4'h0,4'h0,4'h0, 0,1,5,2, 0,0, 0,0,2);
        add(4'h0,4'h8,4'h0,4'h0,4'h0, 0,1,5,2, 2,3, 0,0,2);
        add(4'h0,4'h0,4'h1,4'h0,4'h0, 0,1,5,2, 0,0, 1,2,3);   // tRTW: WR three cycles after RD
        add(4'h0,4'h0,4'h1,4'h0,4'h0, 0,1,5,2, 0,0, 0,0,3);
        add(4'h0,4'h0,4'h1,4'h0,4'h0, 0,1,5,2, 3,0, 0,0,3);
        add(4'h0,4'h2,4'h0,4'h0,4'h0, 0,0,0,0, 0,0, 1,3,0);   // loaded tWTR survives an m1 change
        add(4'h0,4'h2,4'h0,4'h0,4'h0, 0,0,0,0, 0,0, 0,0,0);
        add(4'h0,4'h2,4'h0,4'h0,4'h0, 0,0,0,0, 0,0, 0,0,0);
        add(4'h0,4'h2,4'h0,4'h0,4'h0, 0,0,0,0, 0,0, 0,0,0);
        add(4'h0,4'h2,4'h0,4'h0,4'h0, 0,0,0,0, 0,0, 0,0,0);
        add(4'h1,4'h2,4'h0,4'h8,4'h4, 0,0,0,0, 5,2, 0,0,0);   // class priority REF > RD > ACT > PRE
        add(4'h1,4'h2,4'h0,4'h8,4'h0, 0,0,0,0, 2,1, 1,5,2);
        add(4'h1,4'h0,4'h0,4'h8,4'h0, 0,0,0,0, 1,0, 1,2,1);
        add(4'h0,4'h0,4'h0,4'h8,4'h0, 0,0,0,0, 4,3, 1,1,0);
        add(4'h0,4'h0,4'h0,4'h0,4'h0, 0,0,0,0, 0,0, 1,4,3);

        for (int b = 0; b < NB; b++) begin
            ra[b*RA_W +: RA_W]  = ra_of(b);
            ca[b*CA_W +: CA_W]  = CA_W'(32'h20 + b);
            id[b*ID_W +: ID_W]  = ID_W'(b + 1);
            len[b*LN_W +: LN_W] = LN_W'(32'h10 + b);
        end

        rst_n = 1'b0;
        set_in(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) check_cycle($sformatf("reset%0d", c), 0, 0, 0, 0, 0, '0);
        rst_n = 1'b1;
        check_cycle("release", 5, 0, 0, 0, 0, '0);

        for (int i = 0; i < tbl.size(); i++) begin
            set_in(tbl[i].act, tbl[i].rd, tbl[i].wr, tbl[i].pre, tbl[i].rf,
                   tbl[i].rrd, tbl[i].ccd, tbl[i].wtr, tbl[i].rtw);
            check_cycle($sformatf("vec%0d", i), tbl[i].gt, tbl[i].gb, tbl[i].cv, tbl[i].ct,
                        tbl[i].cb, ra_of(tbl[i].cb));
        end

        // Reset while tRRD is counting: bank1 ACT is eligible right after release.
        set_in(4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 7, 0, 0, 0);
        check_cycle("midrst_act", 1, 0, 0, 0, 3, ra_of(3));
        set_in(4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 7, 0, 0, 0);
        rst_n = 1'b0;
        check_cycle("midrst_hold", 0, 0, 1, 1, 0, ra_of(0));
        rst_n = 1'b1;
        check_cycle("midrst_rel", 1, 1, 0, 0, 0, '0);
        set_in(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
        check_cycle("midrst_cmd", 0, 0, 1, 1, 1, ra_of(1));

        `ifdef DDR_ARB_TFAW_EN
        rst_n = 1'b0;
        check_cycle("faw_rst", 0, 0, 0, 0, 1, ra_of(1));
        rst_n = 1'b1;
        set_in(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
        for (int c = 0; c <= 16; c++) begin
            int gt, gb, cv, ct, cb;
            gt = (c < 4 || c == 16) ? 1 : 0;
            gb = (c < 4) ? c : 0;
            cv = (c >= 1 && c <= 4) ? 1 : 0;
            ct = cv ? 1 : 0;
            cb = (c == 0) ? 0 : ((c <= 4) ? c - 1 : 3);
            check_cycle($sformatf("faw%0d", c), gt, gb, cv, ct, cb, (c == 0) ? '0 : ra_of(cb));
        end
        `endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
